// File: rtl/rf_sum_datapath.sv
// rf_sum_datapath: 8-entry register file with adder, LIMIT comparator and registered output port.
module rf_sum_datapath #(
  parameter int DATA_W = 8,
  parameter int LIMIT  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RFSrcMuxSel,
  input  logic [2:0]        r_addr_1,
  input  logic [2:0]        r_addr_2,
  input  logic [2:0]        wr_addr,
  input  logic              wr_en,
  input  logic              OutPortEn,
  output logic              R1Le10,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid
);
  logic [DATA_W-1:0] rf [0:7];
  logic [DATA_W-1:0] rdata1, rdata2, sum, wdata;
  // rf[0] is reset and never written, so it reads as the hardwired zero
  assign rdata1 = rf[r_addr_1];
  assign rdata2 = rf[r_addr_2];
  assign sum    = rdata1 + rdata2;
  assign wdata  = RFSrcMuxSel ? DATA_W'(1) : sum;
  assign R1Le10 = rdata1 <= DATA_W'(LIMIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr_en && wr_addr != 3'd0) begin
      rf[wr_addr] <= wdata;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= OutPortEn;
      if (OutPortEn) out_port <= rdata1;
    end
  end
endmodule

// File: tb/tb_rf_sum_datapath.sv
// tb_rf_sum_datapath: directed and random checks of rf_sum_datapath against an array model.
module tb_rf_sum_datapath;
  localparam int LIMIT = 10;
  logic clk = 0, rst = 1;
  logic RFSrcMuxSel = 0, wr_en = 0, OutPortEn = 0;
  logic [2:0] r_addr_1 = 0, r_addr_2 = 0, wr_addr = 0;
  logic R1Le10, out_valid;
  logic [7:0] out_port;
  int m [8];
  int mo = 0, mv = 0;
  int passed = 0, total = 0;
  int q [$];
  bit halted;

  rf_sum_datapath #(.DATA_W(8), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .RFSrcMuxSel(RFSrcMuxSel), .r_addr_1(r_addr_1),
    .r_addr_2(r_addr_2), .wr_addr(wr_addr), .wr_en(wr_en), .OutPortEn(OutPortEn),
    .R1Le10(R1Le10), .out_port(out_port), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (m[i]) m[i] = 0;
    mo = 0;
    mv = 0;
  endtask

  // one control word: comparator checked before the edge, output port after it
  task automatic cyc(input bit sel, input int a1, input int a2, input int wa, input bit we, input bit oe);
    int s, wd;
    RFSrcMuxSel = sel; r_addr_1 = 3'(a1); r_addr_2 = 3'(a2);
    wr_addr = 3'(wa); wr_en = we; OutPortEn = oe;
    #1;
    chk("R1Le10", {31'b0, R1Le10}, {31'b0, m[a1] <= LIMIT});
    s = (m[a1] + m[a2]) % 256;
    wd = sel ? 1 : s;
    if (oe) begin mo = m[a1]; mv = 1; end else mv = 0;
    if (we && wa != 0) m[wa] = wd;
    @(posedge clk); #1;
    chk("out_port", 32'(out_port), 32'(mo));
    chk("out_valid", {31'b0, out_valid}, 32'(mv));
  endtask

  task automatic load(input int r, input int v);
    cyc(0, 0, 0, r, 1, 0);
    cyc(1, 0, 0, 7, 1, 0);
    repeat (v) cyc(0, r, 7, r, 1, 0);
  endtask

  task automatic do_reset();
    RFSrcMuxSel = 1; wr_en = 1; wr_addr = 3'(1 + $urandom_range(0, 6)); OutPortEn = 1;
    rst = 1;
    #1;
    chk("rst_out_port", 32'(out_port), 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    model_reset();
    #12 rst = 0;
    @(posedge clk); #1;
    chk("reset_out_port", 32'(out_port), 0);
    chk("reset_out_valid", {31'b0, out_valid}, 0);

    // R0 protection
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("r0_zero", 32'(out_port), 0);

    // add with wrap
    load(1, 200);
    load(2, 100);
    cyc(0, 1, 2, 3, 1, 0);
    cyc(0, 3, 0, 0, 0, 1);
    chk("wrap_sum", 32'(out_port), 44);

    // comparator boundaries
    load(1, 10);
    cyc(0, 1, 0, 0, 0, 0);
    chk("le_10", {31'b0, R1Le10}, 1);
    load(1, 11);
    cyc(0, 1, 0, 0, 0, 0);
    chk("le_11", {31'b0, R1Le10}, 0);
    load(1, 255);
    cyc(0, 1, 0, 0, 0, 0);
    chk("le_255", {31'b0, R1Le10}, 0);

    // read during write: pre-write value captured, new value stored
    load(2, 5);
    load(4, 4);
    cyc(0, 2, 4, 2, 1, 1);
    chk("rdw_out", 32'(out_port), 5);
    cyc(0, 2, 0, 0, 0, 1);
    chk("rdw_new", 32'(out_port), 9);

    // random control words
    for (int k = 0; k < 300; k++)
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));

    // async reset mid-operation with the file loaded
    load(1, 7);
    cyc(0, 1, 0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, i, 0, 0, 0, 1);
      chk("rst_read", 32'(out_port), 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_le", {31'b0, R1Le10}, 1);

    // closed loop, emulating the controller
    do_reset();
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 2, 1, 0);
    cyc(1, 0, 0, 3, 1, 0);
    halted = 0;
    for (int it = 0; it < 20 && !halted; it++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (!R1Le10) halted = 1;
      else begin
        cyc(0, 1, 2, 2, 1, 0);
        cyc(0, 1, 3, 1, 1, 0);
        cyc(0, 2, 0, 0, 0, 1);
        if (out_valid) q.push_back(int'(out_port));
      end
    end
    chk("halt_reached", {31'b0, halted}, 1);
    chk("pulse_count", 32'(q.size()), 11);
    for (int i = 0; i < 11 && i < q.size(); i++)
      chk("partial_sum", 32'(q[i]), 32'(i * (i + 1) / 2));
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    chk("halt_le", {31'b0, R1Le10}, 0);
    chk("halt_hold", 32'(out_port), 55);
    cyc(0, 1, 0, 0, 0, 1);
    chk("halt_r1", 32'(out_port), 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
